// File: rtl/system_pll_phase_ctrl_pkg.sv
// Shared definitions for the PLL dynamic-phase-shift initiator.
// Holds the FSM state codes, the response status codes and the PLL counter-select values.
// Imported by the controller top and by code that builds requests.
package system_pll_phase_ctrl_pkg;

    // FSM state codes
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_SETUP = 3'd1;
    localparam state_t S_PULSE = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_RESP  = 3'd4;

    // Response status codes (2'b11 is reserved and never produced)
    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_UNLOCKED = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;

    // PLL output counter selects
    localparam logic [4:0] CNTSEL_C0  = 5'd0,  CNTSEL_C1  = 5'd1,  CNTSEL_C2  = 5'd2;
    localparam logic [4:0] CNTSEL_C3  = 5'd3,  CNTSEL_C4  = 5'd4,  CNTSEL_C5  = 5'd5;
    localparam logic [4:0] CNTSEL_C6  = 5'd6,  CNTSEL_C7  = 5'd7,  CNTSEL_C8  = 5'd8;
    localparam logic [4:0] CNTSEL_C9  = 5'd9,  CNTSEL_C10 = 5'd10, CNTSEL_C11 = 5'd11;
    localparam logic [4:0] CNTSEL_C12 = 5'd12, CNTSEL_C13 = 5'd13, CNTSEL_C14 = 5'd14;
    localparam logic [4:0] CNTSEL_C15 = 5'd15, CNTSEL_C16 = 5'd16, CNTSEL_C17 = 5'd17;

endpackage

// File: rtl/system_pll_phase_ctrl_sync.sv
// Purpose: multi-flop synchronizer for one asynchronous level signal, reset to 0.
// Latency: STAGES clock cycles from input change to output change.
// Backpressure: none; free-running level path.
module system_pll_phase_ctrl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/system_pll_phase_ctrl.sv
// Purpose: drives the PLL phase_en/updn/cntsel step handshake for a requested step count; macro PHASE_CTRL_TIMEOUT_EN adds a per-step watchdog.
// Latency: 1-step request, phase_en high cycles T+1+SETUP_CYC..T+SETUP_CYC+PULSE_CYC after accept cycle T; rsp_valid after the last phase_done.
// Backpressure: req_ready low from accept until the rsp_valid cycle; rsp has no ready and is a one-cycle pulse.
module system_pll_phase_ctrl
    import system_pll_phase_ctrl_pkg::*;
#(
    parameter int STEP_W      = 10,
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_cnt,
    input  logic              req_updn,
    input  logic [STEP_W-1:0] req_steps,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [STEP_W-1:0] rsp_steps_done,
    output logic              busy,
    input  logic              pll_locked,
    output logic              phase_en,
    output logic              updn,
    output logic [4:0]        cntsel,
    input  logic              phase_done
);

    localparam int PH_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    // Reject configurations the handshake timing cannot honour
    if (SETUP_CYC < 1 || PULSE_CYC < 1 || SYNC_STAGES < 2 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("system_pll_phase_ctrl: parameter out of range");
    end

    state_t            state;
    logic [PH_W-1:0]   ph_cnt;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] done_cnt;
    logic [1:0]        status_q;
    logic              seen_low;
    logic              done_sync;
    logic              locked_sync;

`ifdef PHASE_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]   tmo_cnt;
`endif

    system_pll_phase_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_done (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (phase_done),
        .q     (done_sync)
    );

    system_pll_phase_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_sync)
    );

    // Step sequencer: accept, setup, pulse, wait for phase_done low->high, repeat or respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            ph_cnt         <= '0;
            remaining      <= '0;
            done_cnt       <= '0;
            status_q       <= ST_OK;
            seen_low       <= 1'b0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_status     <= ST_OK;
            rsp_steps_done <= '0;
            phase_en       <= 1'b0;
            updn           <= 1'b0;
            cntsel         <= '0;
`ifdef PHASE_CTRL_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        cntsel    <= req_cnt;
                        updn      <= req_updn;
                        remaining <= req_steps;
                        done_cnt  <= '0;
                        ph_cnt    <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_steps == '0) begin
                            status_q <= ST_OK;
                            state    <= S_RESP;
                        end else if (!locked_sync) begin
                            status_q <= ST_UNLOCKED;
                            state    <= S_RESP;
                        end else begin
                            state    <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (!locked_sync) begin
                        status_q <= ST_UNLOCKED;
                        state    <= S_RESP;
                    end else if (ph_cnt == PH_W'(SETUP_CYC - 1)) begin
                        ph_cnt   <= '0;
                        seen_low <= 1'b0;
                        phase_en <= 1'b1;
                        state    <= S_PULSE;
`ifdef PHASE_CTRL_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                S_PULSE: begin
                    if (!locked_sync) begin
                        phase_en <= 1'b0;
                        status_q <= ST_UNLOCKED;
                        state    <= S_RESP;
                    end else begin
                        // The PLL may drop phase_done while phase_en is still high
                        if (!done_sync) seen_low <= 1'b1;
                        if (ph_cnt == PH_W'(PULSE_CYC - 1)) begin
                            phase_en <= 1'b0;
                            state    <= S_WAIT;
                        end else begin
                            ph_cnt <= ph_cnt + PH_W'(1);
                        end
`ifdef PHASE_CTRL_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + TO_W'(1);
`endif
                    end
                end
                S_WAIT: begin
                    if (!locked_sync) begin
                        status_q <= ST_UNLOCKED;
                        state    <= S_RESP;
                    end else if (seen_low && done_sync) begin
                        done_cnt  <= done_cnt + STEP_W'(1);
                        remaining <= remaining - STEP_W'(1);
                        ph_cnt    <= '0;
                        if (remaining == STEP_W'(1)) begin
                            status_q <= ST_OK;
                            state    <= S_RESP;
                        end else begin
                            state    <= S_SETUP;
                        end
`ifdef PHASE_CTRL_TIMEOUT_EN
                    end else if (tmo_cnt >= TO_W'(TIMEOUT_CYC - 1)) begin
                        status_q <= ST_TIMEOUT;
                        state    <= S_RESP;
`endif
                    end else begin
                        if (!done_sync) seen_low <= 1'b1;
`ifdef PHASE_CTRL_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + TO_W'(1);
`endif
                    end
                end
                S_RESP: begin
                    rsp_valid      <= 1'b1;
                    rsp_status     <= status_q;
                    rsp_steps_done <= done_cnt;
                    req_ready      <= 1'b1;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end
                default: begin
                    phase_en  <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_system_pll_phase_ctrl.sv
// Directed bench for the PLL phase-step initiator with a behavioural PLL phase_done model.
// The model drops phase_done for 4 cycles after each phase_en rise unless held stuck high.
// Define PHASE_CTRL_TIMEOUT_EN on the command line to exercise the watchdog build.
module tb_system_pll_phase_ctrl;
    import system_pll_phase_ctrl_pkg::*;

    localparam int STEP_W    = 10;
    localparam int SETUP_CYC = 1;
    localparam int PULSE_CYC = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [4:0]        req_cnt = '0;
    logic              req_updn = 1'b0;
    logic [STEP_W-1:0] req_steps = '0;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [STEP_W-1:0] rsp_steps_done;
    logic              busy;
    logic              pll_locked = 1'b1;
    logic              phase_en;
    logic              updn;
    logic [4:0]        cntsel;
    logic              phase_done = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   hi_run = 0;
    int   bad_width = 0;
    int   bad_stab = 0;
    int   lowcnt = 0;
    logic pe_prev = 1'b0;
    logic stuck = 1'b0;
    logic [4:0] exp_cnt = '0;
    logic       exp_updn = 1'b0;

    always #5 clk = ~clk;

    system_pll_phase_ctrl #(
        .STEP_W(STEP_W), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC),
        .SYNC_STAGES(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cnt(req_cnt),
        .req_updn(req_updn), .req_steps(req_steps),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_steps_done(rsp_steps_done),
        .busy(busy), .pll_locked(pll_locked),
        .phase_en(phase_en), .updn(updn), .cntsel(cntsel), .phase_done(phase_done)
    );

    // PLL model and pulse monitor, evaluated on the falling edge
    always @(negedge clk) begin
        if (phase_en && !pe_prev) begin
            pulses = pulses + 1;
            lowcnt = 4;
        end
        if (phase_en) begin
            hi_run = hi_run + 1;
        end else if (pe_prev) begin
            if (hi_run != PULSE_CYC) bad_width = bad_width + 1;
            hi_run = 0;
        end
        if (busy && (cntsel !== exp_cnt || updn !== exp_updn)) bad_stab = bad_stab + 1;
        if (stuck) begin
            phase_done = 1'b1;
        end else if (lowcnt > 0) begin
            phase_done = 1'b0;
            lowcnt = lowcnt - 1;
        end else begin
            phase_done = 1'b1;
        end
        pe_prev = phase_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [4:0] c, input logic u, input logic [STEP_W-1:0] s);
        @(negedge clk);
        req_cnt   = c;
        req_updn  = u;
        req_steps = s;
        exp_cnt   = c;
        exp_updn  = u;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Edges counted from the accept edge until rsp_valid is observed
    task automatic wait_rsp(input int max_cyc, output logic seen, output int edges);
        seen  = 1'b0;
        edges = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                seen  = 1'b1;
                edges = i;
                break;
            end
        end
    endtask

    task automatic wait_pe(input int max_cyc, output logic seen, output int edges);
        seen  = 1'b0;
        edges = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (phase_en) begin
                seen  = 1'b1;
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        logic seen;
        int   edges;
        int   base;

        // Reset values while held in reset
        step(3);
        chk("rst_phase_en", phase_en, 0);
        chk("rst_updn", updn, 0);
        chk("rst_cntsel", cntsel, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_status", rsp_status, 0);
        chk("rst_rsp_steps_done", rsp_steps_done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4);

        // 1: three up-steps on C0
        base = pulses;
        chk("t1_ready", req_ready, 1);
        send_req(CNTSEL_C0, 1'b1, 10'd3);
        chk("t1_busy", busy, 1);
        wait_pe(20, seen, edges);
        chk("t1_pe_seen", seen, 1);
        chk("t1_pe_latency", edges + 1, 1 + SETUP_CYC);
        wait_rsp(300, seen, edges);
        chk("t1_rsp_seen", seen, 1);
        chk("t1_status", rsp_status, ST_OK);
        chk("t1_done", rsp_steps_done, 3);
        chk("t1_pulses", pulses - base, 3);
        chk("t1_ready_at_rsp", req_ready, 1);
        chk("t1_busy_at_rsp", busy, 0);
        chk("t1_cntsel", cntsel, 0);
        chk("t1_updn", updn, 1);
        step(1);
        chk("t1_rsp_one_cycle", rsp_valid, 0);
        chk("t1_done_hold", rsp_steps_done, 3);

        // 2: zero steps
        base = pulses;
        send_req(5'd9, 1'b0, 10'd0);
        wait_rsp(20, seen, edges);
        chk("t2_rsp_seen", seen, 1);
        chk("t2_rsp_latency", edges + 1, 2);
        chk("t2_status", rsp_status, ST_OK);
        chk("t2_done", rsp_steps_done, 0);
        chk("t2_pulses", pulses - base, 0);

        // 3: PLL unlocked at accept
        pll_locked = 1'b0;
        step(4);
        base = pulses;
        send_req(5'd7, 1'b0, 10'd5);
        wait_rsp(20, seen, edges);
        chk("t3_rsp_seen", seen, 1);
        chk("t3_status", rsp_status, ST_UNLOCKED);
        chk("t3_done", rsp_steps_done, 0);
        chk("t3_pulses", pulses - base, 0);
        chk("t3_cntsel", cntsel, 7);
        step(3);
        chk("t3_status_hold", rsp_status, ST_UNLOCKED);
        pll_locked = 1'b1;
        step(4);

        // 4: lock lost during the third step's wait
        base = pulses;
        send_req(CNTSEL_C17, 1'b0, 10'd4);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pulses - base >= 3) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        chk("t4_third_pulse", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!phase_en) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        chk("t4_pulse_end", seen, 1);
        pll_locked = 1'b0;
        wait_rsp(50, seen, edges);
        chk("t4_rsp_seen", seen, 1);
        chk("t4_status", rsp_status, ST_UNLOCKED);
        chk("t4_done", rsp_steps_done, 2);
        step(5);
        chk("t4_pulses", pulses - base, 3);
        chk("t4_phase_en_low", phase_en, 0);
        pll_locked = 1'b1;
        step(4);

        // 5: phase_done stuck high
        stuck = 1'b1;
        step(2);
        base = pulses;
        send_req(5'd3, 1'b1, 10'd1);
`ifdef PHASE_CTRL_TIMEOUT_EN
        wait_rsp(80, seen, edges);
        chk("t5_rsp_seen", seen, 1);
        chk("t5_status", rsp_status, ST_TIMEOUT);
        chk("t5_done", rsp_steps_done, 0);
        chk("t5_pulses", pulses - base, 1);
        stuck = 1'b0;
        step(10);
`else
        wait_rsp(40, seen, edges);
        chk("t5_no_rsp", seen, 0);
        chk("t5_busy_held", busy, 1);
        chk("t5_pulses", pulses - base, 1);
        stuck = 1'b0;
        wait_rsp(50, seen, edges);
        chk("t5_late_rsp_seen", seen, 1);
        chk("t5_late_status", rsp_status, ST_OK);
        chk("t5_late_done", rsp_steps_done, 1);
`endif
        step(2);

        chk("pulse_width_errors", bad_width, 0);
        chk("cntsel_updn_stability_errors", bad_stab, 0);

        // 6: asynchronous reset while phase_en is high
        send_req(5'd5, 1'b1, 10'd3);
        wait_pe(20, seen, edges);
        chk("t6_pe_seen", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_phase_en", phase_en, 0);
        chk("t6_req_ready", req_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_cntsel", cntsel, 0);
        chk("t6_updn", updn, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_status", rsp_status, 0);
        chk("t6_rsp_steps_done", rsp_steps_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        chk("t6_ready_after", req_ready, 1);
        chk("t6_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
